// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// encoding helpers, parametrised by exponent/fraction widths.
package fp_pkg;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Encodings are built in a 64-bit container; callers slice to their width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << (exp_w + 1)) - 64'd1;
    return ones << (man_w - 1);
  endfunction

  function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r[exp_w + man_w] = sign;
    return r;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, range check and pack of a normalised significand.
// Shared by the multiplier's last stage and future add/sub datapaths.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exp_in,
  input  logic [MAN_W-1:0]         frac,
  input  logic                     guard,
  input  logic                     sticky,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);

  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [EXP_W+1:0] EMAX_S = EMAX[EXP_W+1:0];
  localparam logic signed [EXP_W+1:0] EZERO  = '0;

  logic                    round_up;
  logic [MAN_W:0]          frac_sum;
  logic signed [EXP_W+1:0] exp_r;

  always_comb begin
    round_up = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    // A carry out of the fraction leaves frac_sum[MAN_W-1:0] at zero already.
    exp_r    = exp_in + $signed({{(EXP_W+1){1'b0}}, frac_sum[MAN_W]});
    flags    = '0;
    flags[FLAG_INEXACT] = guard | sticky;
    result   = {sign, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    if (exp_r >= EMAX_S) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_r <= EZERO) begin
      result = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage streaming floating-point multiplier (classify/multiply,
// normalise, round/pack) with a single global stall enable.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   mul_result,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int SW = EXP_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic signed [SW-1:0] BIAS_S = SW'(BIAS);
  localparam logic [63:0] QNAN64 = fp_qnan(EXP_W, MAN_W);
  localparam logic [63:0] INF64  = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN  = QNAN64[W-1:0];
  localparam logic [W-1:0] INF   = INF64[W-1:0];

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return FP_ZERO;
    if (e == '1) begin
      if (f == '0) return FP_INF;
      if (f[MAN_W-1]) return FP_QNAN;
      return FP_SNAN;
    end
    return FP_NORM;
  endfunction

  logic adv, take;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & nreset;
  assign take     = in_valid & in_ready;

  logic             sa, sb, sign;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        ca, cb;
  logic             nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;

  assign {sa, ea, fa} = A;
  assign {sb, eb, fb} = B;
  assign sign   = sa ^ sb;
  assign ca     = classify(ea, fa);
  assign cb     = classify(eb, fb);
  assign snan_a = (ca == FP_SNAN);
  assign snan_b = (cb == FP_SNAN);
  assign nan_a  = snan_a || (ca == FP_QNAN);
  assign nan_b  = snan_b || (cb == FP_QNAN);
  assign inf_a  = (ca == FP_INF);
  assign inf_b  = (cb == FP_INF);
  assign zero_a = (ca == FP_ZERO);
  assign zero_b = (cb == FP_ZERO);

  logic                 sp_hit;
  logic [W-1:0]         sp_res;
  logic [3:0]           sp_flags;
  logic [PW-1:0]        prod;
  logic signed [SW-1:0] esum;

  // Special operands bypass the arithmetic and are resolved here, in priority order.
  always_comb begin
    sp_hit   = 1'b1;
    sp_res   = QNAN;
    sp_flags = '0;
    if (nan_a || nan_b)
      sp_flags[FLAG_INVALID] = snan_a | snan_b;
    else if ((inf_a && zero_b) || (zero_a && inf_b))
      sp_flags[FLAG_INVALID] = 1'b1;
    else if (inf_a || inf_b)
      sp_res = {sign, INF[W-2:0]};
    else if (zero_a || zero_b)
      sp_res = {sign, {(W-1){1'b0}}};
    else
      sp_hit = 1'b0;
  end

  assign prod = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};
  assign esum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

  logic                 s1_valid, s1_sign, s1_sp_hit;
  logic signed [SW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;
  logic [W-1:0]         s1_sp_res;
  logic [3:0]           s1_sp_flags;

  logic [PW-2:0]        norm;
  logic signed [SW-1:0] n_exp;

  assign norm  = s1_prod[PW-1] ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
  assign n_exp = s1_exp + $signed({{(SW-1){1'b0}}, s1_prod[PW-1]});

  logic                 s2_valid, s2_sign, s2_guard, s2_sticky, s2_sp_hit;
  logic signed [SW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_frac;
  logic [W-1:0]         s2_sp_res;
  logic [3:0]           s2_sp_flags;
  logic [W-1:0]         rp_result;
  logic [3:0]           rp_flags;

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (s2_sign),
    .exp_in (s2_exp),
    .frac   (s2_frac),
    .guard  (s2_guard),
    .sticky (s2_sticky),
    .result (rp_result),
    .flags  (rp_flags)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_prod     <= '0;
      s1_sp_hit   <= 1'b0;
      s1_sp_res   <= '0;
      s1_sp_flags <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_exp      <= '0;
      s2_frac     <= '0;
      s2_guard    <= 1'b0;
      s2_sticky   <= 1'b0;
      s2_sp_hit   <= 1'b0;
      s2_sp_res   <= '0;
      s2_sp_flags <= '0;
      out_valid   <= 1'b0;
      mul_result  <= '0;
      flags       <= '0;
    end else if (adv) begin
      s1_valid <= take;
      if (take) begin
        s1_sign     <= sign;
        s1_exp      <= esum;
        s1_prod     <= prod;
        s1_sp_hit   <= sp_hit;
        s1_sp_res   <= sp_res;
        s1_sp_flags <= sp_flags;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign     <= s1_sign;
        s2_exp      <= n_exp;
        s2_frac     <= norm[PW-2:MAN_W+1];
        s2_guard    <= norm[MAN_W];
        s2_sticky   <= |norm[MAN_W-1:0];
        s2_sp_hit   <= s1_sp_hit;
        s2_sp_res   <= s1_sp_res;
        s2_sp_flags <= s1_sp_flags;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        mul_result <= s2_sp_hit ? s2_sp_res   : rp_result;
        flags      <= s2_sp_hit ? s2_sp_flags : rp_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: vector table, streaming, backpressure,
// mid-stream reset and a binary16 instance.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, mul_result;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] hA, hB, h_res;
  logic [3:0]  h_flags;

  fp_mul_pipe dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .mul_result(mul_result), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .nreset(nreset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .A(hA), .B(hB), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .mul_result(h_res), .flags(h_flags)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[14];
  int   sel[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic single(input int i);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; A = vecs[i].a; B = vecs[i].b;
    @(negedge clk);
    in_valid = 1'b0; A = 32'hDEADBEEF; B = 32'hDEADBEEF;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    check($sformatf("vec%0d_result", i), mul_result, vecs[i].res);
    check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].fl));
  endtask

  // Drives sel[] back-to-back while holding out_ready low for the first
  // 'stall' cycles; every output transfer is checked for value and cycle.
  task automatic run_stream(input string tag, input int stall);
    int k, idx, n, first;
    k = 0; idx = 0; n = sel.size();
    first = (stall > 3) ? stall : 3;
    for (int cyc = 0; cyc < stall + n + 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      if (k < n) begin
        in_valid = 1'b1; A = vecs[sel[k]].a; B = vecs[sel[k]].b;
      end else begin
        in_valid = 1'b0; A = 32'hDEADBEEF; B = 32'hDEADBEEF;
      end
      #1;
      check($sformatf("%s_in_ready_c%0d", tag, cyc), 32'(in_ready), 32'(!(cyc >= 3 && cyc < stall)));
      if (cyc >= 3 && cyc < stall) begin
        check($sformatf("%s_hold_valid_c%0d", tag, cyc), 32'(out_valid), 32'd1);
        check($sformatf("%s_hold_result_c%0d", tag, cyc), mul_result, vecs[sel[0]].res);
      end
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) begin
        if (idx < n) begin
          check($sformatf("%s_result%0d", tag, idx), mul_result, vecs[sel[idx]].res);
          check($sformatf("%s_flags%0d", tag, idx), 32'(flags), 32'(vecs[sel[idx]].fl));
          check($sformatf("%s_cycle%0d", tag, idx), 32'(cyc), 32'(first + idx));
        end else begin
          check($sformatf("%s_extra_result", tag), 32'(idx + 1), 32'(n));
        end
        idx++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check($sformatf("%s_count", tag), 32'(idx), 32'(n));
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0};
    vecs[1]  = '{32'h40000000, 32'h3FC00000, 32'h40400000, 4'h0};
    vecs[2]  = '{32'hC0000000, 32'h3FC00000, 32'hC0400000, 4'h0};
    vecs[3]  = '{32'h414B94E2, 32'h443EF4BC, 32'h4617DB1F, 4'h1};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8};
    vecs[5]  = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 4'h0};
    vecs[6]  = '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'h8};
    vecs[7]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5};
    vecs[8]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'h3};
    vecs[9]  = '{32'h00000001, 32'h40000000, 32'h00000000, 4'h0};
    vecs[10] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0};
    vecs[11] = '{32'h00000000, 32'hBF800000, 32'h80000000, 4'h0};
    vecs[12] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1};
    vecs[13] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1};

    nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; hA = '0; hB = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", mul_result, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_h_out_valid", 32'(h_out_valid), 32'd0);
    nreset = 1'b1;

    for (int i = 0; i < 14; i++) single(i);

    sel = {0, 1, 2, 3, 4, 5};
    run_stream("stream", 0);

    sel = {3, 7, 12, 13};
    run_stream("bp", 5);

    @(negedge clk);
    in_valid = 1'b1; A = vecs[0].a; B = vecs[0].b;
    @(negedge clk);
    A = vecs[1].a; B = vecs[1].b;
    @(negedge clk);
    in_valid = 1'b0; nreset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", mul_result, 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("midrst_stale_c%0d", c), 32'(out_valid), 32'd0);
    end

    @(negedge clk);
    h_in_valid = 1'b1; hA = 16'h3E00; hB = 16'h3E00;
    @(negedge clk);
    h_in_valid = 1'b0; hA = 16'hBEEF; hB = 16'hBEEF;
    lat = 1;
    while (!h_out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("h16_latency", 32'(lat), 32'd3);
    check("h16_result", 32'(h_res), 32'h4080);
    check("h16_flags", 32'(h_flags), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
